game_flow_controller: RTL

Top-level game sequencer that owns the life/damage tracker's lifecycle.
- Sequences idle → clear → countdown → play → pause/game-over.
- Generates the tracker's active-low clear pulse and gates the game tick so damage and cooldown only advance during active play.
- Sits between the debounced buttons/tick generator and the health, collision and display logic.

---
 rtl/game_flow_controller_pkg.sv | 22 ++
 rtl/game_flow_controller_edge_detect.sv | 26 ++
 rtl/game_flow_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the game flow sequencer: state encodings and the
// default timing constants, also reused by the display block.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PLAY      = 3'd3,
        ST_PAUSED    = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic [3:0] DEF_HEALTH_CLR_CYCLES = 4'd4;
    localparam logic [7:0] DEF_COUNTDOWN_TICKS   = 8'd40;
    localparam logic [7:0] DEF_GAMEOVER_TICKS    = 8'd60;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/game_flow_controller_edge_detect.sv
// One-bit rising-edge detector. The first clk after reset only samples the
// level, so a button held through reset never reports a rise.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;
    logic armed_q;

    // NOTE: state flops use non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            level_q <= level;
            armed_q <= 1'b1;
        end
    end

    assign rise = level & ~level_q & armed_q;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: idle -> clear -> countdown -> play -> pause/game-over.
// Drives the health tracker's clear pulse and gates the game tick to active play.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter logic [3:0] HEALTH_CLR_CYCLES = DEF_HEALTH_CLR_CYCLES,
    parameter logic [7:0] COUNTDOWN_TICKS   = DEF_COUNTDOWN_TICKS,
    parameter logic [7:0] GAMEOVER_TICKS    = DEF_GAMEOVER_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       is_dead,
    output logic [2:0] state,
    output logic       health_rst_n,
    output logic       game_run,
    output logic [7:0] timer,
    output logic [7:0] games_played
);

    state_t     state_q, state_d;
    logic [3:0] clr_q, clr_d;
    logic [7:0] timer_d;
    logic [7:0] games_d;
    logic       start_rise;
    logic       pause_rise;

    edge_detect u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .level (start_btn),
        .rise  (start_rise)
    );

    edge_detect u_pause_edge (
        .clk   (clk),
        .rst   (rst),
        .level (pause_btn),
        .rise  (pause_rise)
    );

    // health_rst_n is registered from the next state so it is low exactly
    // for the cycles spent in CLEAR and never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            clr_q        <= '0;
            timer        <= '0;
            games_played <= '0;
            health_rst_n <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_q        <= clr_d;
            timer        <= timer_d;
            games_played <= games_d;
            health_rst_n <= (state_d != ST_CLEAR);
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        timer_d = timer;
        games_d = games_played;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_CLEAR;
                    clr_d   = HEALTH_CLR_CYCLES;
                    timer_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_q <= 4'd1) begin
                    state_d = ST_COUNTDOWN;
                    clr_d   = '0;
                    timer_d = COUNTDOWN_TICKS;
                end else begin
                    clr_d = clr_q - 4'd1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (timer == 8'd1) begin
                        state_d = ST_PLAY;
                        timer_d = '0;
                    end else if (timer != 8'd0) begin
                        timer_d = timer - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (is_dead) begin
                    state_d = ST_GAME_OVER;
                    timer_d = GAMEOVER_TICKS;
                    games_d = sat_inc8(games_played);
                end else if (pause_rise) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (start_rise) begin
                    state_d = ST_CLEAR;
                    clr_d   = HEALTH_CLR_CYCLES;
                    timer_d = '0;
                end else if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d = ST_CLEAR;
                    clr_d   = HEALTH_CLR_CYCLES;
                    timer_d = '0;
                end else if (tick) begin
                    if (timer == 8'd1) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (timer != 8'd0) begin
                        timer_d = timer - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state    = state_q;
        game_run = tick & (state_q == ST_PLAY);
    end

endmodule
